// File: rtl/gate_chk_pkg.sv
// ============================================================================
// gate_chk_pkg : op_sel encodings and FSM states for the gate truth-table checker
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package gate_chk_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gate_truth_table_checker_ref.sv
// ============================================================================
// gate_ref_model : combinational expected output for the selected gate function
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] op_sel,
  input  logic       A,
  input  logic       B,
  output logic       expected_y
);

  // Reserved encodings 6-7 fall through to NAND.
  always_comb begin
    expected_y = ~(A & B);
    case (op_sel)
      OP_AND:  expected_y = A & B;
      OP_OR:   expected_y = A | B;
      OP_NAND: expected_y = ~(A & B);
      OP_NOR:  expected_y = ~(A | B);
      OP_XOR:  expected_y = A ^ B;
      OP_XNOR: expected_y = ~(A ^ B);
      default: expected_y = ~(A & B);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_truth_table_checker.sv
// ============================================================================
// gate_truth_table_checker : walks {A,B} through 00..11, compares Y to op_sel
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module gate_truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op_sel,
  output logic       A,
  output logic       B,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             w_expected;
  logic             w_mismatch;

  gate_ref_model u_ref (
    .op_sel     (r_op),
    .A          (A),
    .B          (B),
    .expected_y (w_expected)
  );

  assign w_mismatch = (Y != w_expected);
  assign busy       = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign pass       = done && (err_count == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= 3'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      done      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_op      <= op_sel;
            err_count <= 3'd0;
            fail_vec  <= 2'b00;
            done      <= 1'b0;
            {A, B}    <= 2'b00;
            r_cnt     <= c_SETTLE_LOAD;
            r_state   <= ST_SETTLE;
          end
        end
        // Counter holds SETTLE_CYCLES on entry, so SETTLE lasts that many cycles.
        ST_SETTLE: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (w_mismatch) begin
            if (err_count != 3'd7) begin
              err_count <= err_count + 3'd1;
            end
            if (err_count == 3'd0) begin
              fail_vec <= {A, B};
            end
          end
          if ({A, B} != 2'b11) begin
            {A, B}  <= {A, B} + 2'd1;
            r_cnt   <= c_SETTLE_LOAD;
            r_state <= ST_SETTLE;
          end else begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_table_checker.sv
// ============================================================================
// tb_gate_truth_table_checker : randomized gates vs. truth-table model, two settle depths
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_gate_truth_table_checker;

  localparam int S2 = 2;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start2, start1;
  logic [2:0] op2, op1;
  logic       a2, b2, a1, b1;
  logic       y2, y1;
  logic       busy2, done2, pass2, busy1, done1, pass1;
  logic [2:0] err2, err1;
  logic [1:0] fv2, fv1;
  logic [3:0] gut_tt;   // truth table of the emulated gate, indexed by {A,B}

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y2 = gut_tt[{a2, b2}];
  assign y1 = 1'b1;

  gate_truth_table_checker #(.SETTLE_CYCLES(S2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op_sel(op2),
    .A(a2), .B(b2), .Y(y2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fv2)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_sel(op1),
    .A(a1), .B(b1), .Y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1)
  );

  // Expected gate truth table derived from the count of high inputs.
  function automatic logic [3:0] spec_table(input logic [2:0] op);
    logic [3:0] t;
    int ones;
    t = 4'b0000;
    for (int v = 0; v < 4; v++) begin
      ones = (v >> 1) + (v & 1);
      case (op)
        3'd0:    t[v] = (ones == 2);
        3'd1:    t[v] = (ones >= 1);
        3'd3:    t[v] = (ones == 0);
        3'd4:    t[v] = (ones == 1);
        3'd5:    t[v] = (ones != 1);
        default: t[v] = (ones != 2);
      endcase
    end
    return t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start2 = 1'b1; start1 = 1'b1; op2 = 3'd0; op1 = 3'd2;
    gut_tt = spec_table(3'd2);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a2, b2, busy2, done2, pass2, err2, fv2} !== 10'b0) begin
      errors++;
      $display("FAIL reset_dut2 got %b exp %b", {a2, b2, busy2, done2, pass2, err2, fv2}, 10'b0);
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, fv1} !== 10'b0) begin
      errors++;
      $display("FAIL reset_dut1 got %b exp %b", {a1, b1, busy1, done1, pass1, err1, fv1}, 10'b0);
    end
    @(negedge clk);
    start2 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy2, done2);
    end
  endtask

  // Full run on the S2 instance: per-edge timing plus model-predicted results.
  task automatic run_checked(input string name, input logic [2:0] op);
    int         n;
    int         exp_err;
    logic [1:0] exp_fail;
    logic [3:0] exp_tt;
    logic [1:0] vec;
    bit         seen;
    n = 4 * (S2 + 1);
    exp_tt = spec_table(op);
    exp_err = 0; exp_fail = 2'b00; seen = 1'b0;
    for (int v = 0; v < 4; v++) begin
      if (exp_tt[v] !== gut_tt[v]) begin
        exp_err++;
        if (!seen) begin
          exp_fail = 2'(v);
          seen = 1'b1;
        end
      end
    end

    @(negedge clk);
    op2 = op; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0; op2 = ~op;
    checks++;
    if ({busy2, done2, a2, b2, err2} !== 7'b1000000) begin
      errors++;
      $display("FAIL %s accept got busy=%b done=%b ab=%b%b err=%0d exp 1 0 00 0", name, busy2, done2, a2, b2, err2);
    end
    for (int k = 1; k <= n; k++) begin
      start2 = (k == 5);
      @(posedge clk);
      #1;
      if (k < n) begin
        vec = 2'(k / (S2 + 1));
        checks++;
        if ({busy2, done2, a2, b2} !== {2'b10, vec}) begin
          errors++;
          $display("FAIL %s edge%0d got busy=%b done=%b ab=%b%b exp 1 0 %b", name, k, busy2, done2, a2, b2, vec);
        end
      end else begin
        checks++;
        if ({busy2, done2, a2, b2} !== 4'b0111) begin
          errors++;
          $display("FAIL %s done_edge got busy=%b done=%b ab=%b%b exp 0 1 11", name, busy2, done2, a2, b2);
        end
      end
    end
    start2 = 1'b0;
    checks++;
    if (err2 !== 3'(exp_err) || fv2 !== exp_fail || pass2 !== (exp_err == 0)) begin
      errors++;
      $display("FAIL %s result got err=%0d fv=%b pass=%b exp err=%0d fv=%b pass=%b",
               name, err2, fv2, pass2, exp_err, exp_fail, (exp_err == 0));
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done2, busy2, a2, b2, err2} !== {4'b1011, 3'(exp_err)}) begin
      errors++;
      $display("FAIL %s hold got done=%b busy=%b ab=%b%b err=%0d exp 1 0 11 %0d", name, done2, busy2, a2, b2, err2, exp_err);
    end
  endtask

  task automatic test_directed();
    gut_tt = spec_table(3'd2);
    run_checked("nand_pass", 3'd2);
    run_checked("and_vs_nand", 3'd0);
    run_checked("xor_vs_nand", 3'd4);
    run_checked("xnor_vs_nand", 3'd5);
    run_checked("reserved7", 3'd7);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      gut_tt = 4'($urandom_range(0, 15));
      run_checked("random", 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_start_held();
    int n;
    n = 4 * (S2 + 1);
    gut_tt = spec_table(3'd2);
    @(negedge clk);
    op2 = 3'd2; start2 = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) op2 = 3'd0;
    end
    checks++;
    if ({done2, pass2, err2} !== 5'b11000) begin
      errors++;
      $display("FAIL held_first_run got done=%b pass=%b err=%0d exp 1 1 0", done2, pass2, err2);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy2, done2, a2, b2, err2} !== 7'b1000000) begin
      errors++;
      $display("FAIL held_restart got busy=%b done=%b ab=%b%b err=%0d exp 1 0 00 0", busy2, done2, a2, b2, err2);
    end
    start2 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    checks++;
    if ({done2, pass2, err2, fv2} !== 7'b1010000) begin
      errors++;
      $display("FAIL held_second_run got done=%b pass=%b err=%0d fv=%b exp 1 0 4 00", done2, pass2, err2, fv2);
    end
  endtask

  task automatic test_reset_midrun();
    gut_tt = spec_table(3'd2);
    @(negedge clk);
    op2 = 3'd0; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (err2 !== 3'd2 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL midrun_progress got err=%0d busy=%b exp 2 1", err2, busy2);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a2, b2, busy2, done2, pass2, err2, fv2} !== 10'b0) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", {a2, b2, busy2, done2, pass2, err2, fv2}, 10'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_checked("after_reset", 3'd2);
  endtask

  task automatic test_settle1();
    @(negedge clk);
    op1 = 3'd2; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done1 !== (k == 8)) begin
        errors++;
        $display("FAIL s1_done_edge%0d got %b exp %b", k, done1, (k == 8));
      end
    end
    checks++;
    if ({err1, fv1, pass1} !== 6'b001110) begin
      errors++;
      $display("FAIL s1_stuck1 got err=%0d fv=%b pass=%b exp 1 11 0", err1, fv1, pass1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_reset_midrun();
    test_settle1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
